if_fetch: RTL

IF_FETCH -- requirements
Module: if_fetch

---
 rtl/if_fetch.sv | 97 +++++++++
 1 files changed

// File: rtl/if_fetch.sv
// Instruction fetch stage: credit-limited request issue on the instruction bus,
// a 2-entry {pc, inst} FIFO presented combinationally, and redirect with response discard.
module if_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        jump_flag,
  input  logic [31:0] jump_addr,
  input  logic        hold,
  output logic        ibus_req,
  output logic [31:0] ibus_addr,
  input  logic        ibus_gnt,
  input  logic        ibus_rvalid,
  input  logic [31:0] ibus_rdata,
  output logic [31:0] if_pc,
  output logic [31:0] if_inst,
  output logic        if_valid
);

  logic [31:0] fetch_pc;
  logic [31:0] fifo_pc   [2];
  logic [31:0] fifo_inst [2];
  logic        rd_ptr;
  logic        wr_ptr;
  logic [1:0]  occupancy;
  logic [1:0]  outstanding;
  logic [1:0]  discard;
  logic [31:0] req_pc    [2];

  logic        credit;
  logic        fire;
  logic        resp;
  logic        push;
  logic        pop;
  logic [1:0]  out_after_resp;
  logic        unused_jump_lsbs;

  assign unused_jump_lsbs = ^jump_addr[1:0];

  // Credit counts FIFO entries plus in-flight requests so a response always has a slot.
  always_comb begin
    credit         = ({1'b0, occupancy} + {1'b0, outstanding}) < 3'd2;
    ibus_req       = credit & ~jump_flag & ~rst;
    ibus_addr      = rst ? RESET_PC : fetch_pc;
    fire           = ibus_req & ibus_gnt;
    resp           = ibus_rvalid & (outstanding != 2'd0) & ~rst;
    push           = resp & (discard == 2'd0) & ~jump_flag;
    out_after_resp = outstanding - {1'b0, resp};
    if_valid       = (occupancy != 2'd0) & ~rst;
    if_pc          = if_valid ? fifo_pc[rd_ptr] : 32'd0;
    if_inst        = if_valid ? fifo_inst[rd_ptr] : NOP_INST;
    pop            = if_valid & ~hold & ~jump_flag;
  end

  // A redirect flushes the FIFO and marks every still-pending response as stale.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc    <= RESET_PC;
      rd_ptr      <= 1'b0;
      wr_ptr      <= 1'b0;
      occupancy   <= 2'd0;
      outstanding <= 2'd0;
      discard     <= 2'd0;
    end else begin
      outstanding <= out_after_resp + {1'b0, fire};
      if (jump_flag) begin
        fetch_pc  <= {jump_addr[31:2], 2'b00};
        rd_ptr    <= 1'b0;
        wr_ptr    <= 1'b0;
        occupancy <= 2'd0;
        discard   <= out_after_resp;
      end else begin
        if (fire) fetch_pc <= fetch_pc + 32'd4;
        if (resp && discard != 2'd0) discard <= discard - 2'd1;
        if (push) wr_ptr <= ~wr_ptr;
        if (pop) rd_ptr <= ~rd_ptr;
        occupancy <= occupancy + {1'b0, push} - {1'b0, pop};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_pc[wr_ptr]   <= req_pc[0];
      fifo_inst[wr_ptr] <= ibus_rdata;
    end
  end

  // Request PCs kept oldest-first; a grant overrides the shift when it lands in slot 0.
  always_ff @(posedge clk) begin
    if (resp) req_pc[0] <= req_pc[1];
    if (fire) req_pc[out_after_resp[0]] <= fetch_pc;
  end

endmodule
